mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Execute-stage multiply/divide unit owning the HI/LO registers.
- Consumes the one-hot R-type strobes produced by the instruction decoder (mult, multu, div, divu, mfhi, mflo, mthi, mtlo) together with the E-stage operands.
- Models fixed multi-cycle latency with a busy counter so the hazard unit can stall later HI/LO users.
- Provides the mfhi/mflo read value to the E-stage result mux.

Parameters:
- MULT_CYCLES, 5, busy duration in cycles for mult/multu (must be at least 1).
- DIV_CYCLES, 10, busy duration in cycles for div/divu (must be at least 1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  E-stage instruction valid and R-type; all strobes are ignored when low.
- mult  input  1  signed multiply strobe.
- multu  input  1  unsigned multiply strobe.
- div  input  1  signed divide strobe.
- divu  input  1  unsigned divide strobe.
- mfhi  input  1  read HI.
- mflo  input  1  read LO.
- mthi  input  1  write a to HI.
- mtlo  input  1  write a to LO.
- a  input  32  rs operand, already forwarded.
- b  input  32  rt operand, already forwarded.
- start  output  1  combinational; en & (mult|multu|div|divu) & ~busy.
- md_use  output  1  combinational; en & any of the 8 strobes. The hazard unit stalls when md_use & (start|busy).
- busy  output  1  registered; an operation is in flight.
- hi  output  32  registered HI.
- lo  output  32  registered LO.
- rdata  output  32  combinational; hi if mfhi, else lo if mflo, else 0.

Behaviour:
- Clock and reset: one clock, reset is synchronous and active-high.
- Reset values: hi=0, lo=0, busy=0, internal counter=0, pending result=0. A reset asserted mid-operation aborts it; HI/LO are not updated with the pending result.
- States: IDLE (busy=0) and RUN (busy=1, counter=1..N).

IDLE:
- On an edge where start=1, the result is computed from a/b and held in 64-bit pending registers.
- counter is loaded with N (MULT_CYCLES or DIV_CYCLES), busy goes to 1, and the unit enters RUN.
- HI/LO are unchanged at that edge.

RUN:
- counter decrements each edge.
- At the edge where counter==1, HI/LO are loaded from pending, busy goes to 0, and the unit returns to IDLE.
- busy is therefore high for exactly N cycles, T+1..T+N, after the start edge T. New HI/LO are visible in cycle T+N+1.

Arithmetic:
- mult: signed 32x32 to 64 bits; hi = product[63:32], lo = product[31:0].
- multu: same split, unsigned.
- div: signed, quotient truncates toward zero; lo = quotient, hi = remainder, and the remainder takes the sign of the dividend a.
- divu: unsigned.
- Divide by zero (b=0): the operation still occupies DIV_CYCLES, and HI/LO are left unchanged at completion.
- 0x80000000 / 0xFFFFFFFF (signed): lo = 0x80000000, hi = 0.

mthi/mtlo:
- Act only when en=1 and busy=0: HI or LO is written with a at the next edge.
- Ignored while busy, because the hazard unit guarantees they are stalled.

Strobe validity and priority:
- Strobes with en=0 have no effect.
- More than one strobe is illegal. If it occurs anyway, priority is mult > multu > div > divu > mthi > mtlo, and only one action is taken.
- Start strobes asserted while busy=1 are ignored (start=0); the operation in flight continues unaffected.
- Back-to-back operation: a new start is accepted in cycle T+N+1, the first cycle with busy=0.

rdata:
- Purely combinational from the current hi/lo registers.
- No bypass of pending results, and no bypass of same-cycle mthi/mtlo.

Test Plan:
- Reset for 2 cycles, then idle: hi=lo=0, busy=0, rdata=0 with mfhi=1.
- mult, a=0xFFFFFFFE (-2), b=3 at edge T:
  - busy=1 for cycles T+1..T+5, with hi/lo unchanged during that window;
  - in cycle T+6, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - multu with the same operands gives hi=0x00000002, lo=0xFFFFFFFA.
- div, a=-7 (0xFFFFFFF9), b=2: busy for 10 cycles, then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). divu, a=7, b=2 gives lo=3, hi=1.
- Preload with mthi 0x11111111 and mtlo 0x22222222, then div with b=0: busy for 10 cycles; afterwards hi=0x11111111, lo=0x22222222.
- Issue a second mult and an mtlo while busy: start=0, md_use=1, and neither the in-flight result nor LO is disturbed. After completion, mfhi returns the first product's HI via rdata.
- Assert reset at cycle T+3 of a mult: the next cycle shows busy=0 and hi=lo=0, and no late update occurs in the following 10 cycles.

Source files
------------

// File: rtl/mult_div_unit.sv
// mult_div_unit: execute-stage multiply/divide unit owning HI/LO with fixed-latency busy tracking
module mult_div_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic        mult,
   input  logic        multu,
   input  logic        div,
   input  logic        divu,
   input  logic        mfhi,
   input  logic        mflo,
   input  logic        mthi,
   input  logic        mtlo,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        start,
   output logic        md_use,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] rdata
);
   localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t             state;
   logic [CW-1:0]      cnt;
   logic [63:0]        pend;
   logic               pend_ok;
   logic signed [63:0] sa, sb;
   logic [63:0]        smul, umul, res;
   logic [31:0]        aa, ab, abd, bd, uq, ur, sq, sr, dq, dr;

   assign start  = en & (mult | multu | div | divu) & ~busy;
   assign md_use = en & (mult | multu | div | divu | mfhi | mflo | mthi | mtlo);
   assign rdata  = mfhi ? hi : mflo ? lo : '0;

   // result datapath; divisor forced to 1 on zero so the divider never sees 0 (result is discarded)
   always_comb begin
      sa   = {{32{a[31]}}, a};
      sb   = {{32{b[31]}}, b};
      smul = sa * sb;
      umul = {32'b0, a} * {32'b0, b};
      aa   = a[31] ? -a : a;
      ab   = b[31] ? -b : b;
      abd  = (b == '0) ? 32'd1 : ab;
      bd   = (b == '0) ? 32'd1 : b;
      uq   = aa / abd;
      ur   = aa % abd;
      sq   = (a[31] ^ b[31]) ? -uq : uq;
      sr   = a[31] ? -ur : ur;
      dq   = a / bd;
      dr   = a % bd;
      res  = mult ? smul : multu ? umul : div ? {sr, sq} : {dr, dq};
   end

   // IDLE/RUN sequencer: capture result at start, count down, commit to HI/LO on the last busy cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         busy    <= 1'b0;
         cnt     <= '0;
         pend    <= '0;
         pend_ok <= 1'b0;
         hi      <= '0;
         lo      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  pend    <= res;
                  pend_ok <= mult | multu | (b != '0);
                  cnt     <= (mult | multu) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                  busy    <= 1'b1;
                  state   <= RUN;
               end else if (en & mthi) begin
                  hi <= a;
               end else if (en & mtlo) begin
                  lo <= a;
               end
            end
            RUN: begin
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  if (pend_ok) begin
                     hi <= pend[63:32];
                     lo <= pend[31:0];
                  end
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed stimulus with a cycle-level HI/LO model checked every cycle
module tb_mult_div_unit;
   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk = 1'b0;
   logic        reset, en, mult, multu, div, divu, mfhi, mflo, mthi, mtlo;
   logic [31:0] a, b;
   logic        start, md_use, busy;
   logic [31:0] hi, lo, rdata;

   int passed = 0;
   int total  = 0;

   mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk(clk), .reset(reset), .en(en), .mult(mult), .multu(multu), .div(div), .divu(divu),
      .mfhi(mfhi), .mflo(mflo), .mthi(mthi), .mtlo(mtlo), .a(a), .b(b),
      .start(start), .md_use(md_use), .busy(busy), .hi(hi), .lo(lo), .rdata(rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
   endtask

   // reference arithmetic in plain 64-bit integer terms
   function automatic logic [63:0] calc(input int op, input logic [31:0] x, input logic [31:0] y);
      longint sx, sy, q, r;
      longint unsigned ux, uy;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = {32'b0, x};
      uy = {32'b0, y};
      case (op)
         0: return sx * sy;
         1: return ux * uy;
         2: begin q = sx / sy; r = sx % sy; return {r[31:0], q[31:0]}; end
         default: begin q = longint'(ux / uy); r = longint'(ux % uy); return {r[31:0], q[31:0]}; end
      endcase
   endfunction

   // model state: edge counter, edge at which the in-flight op completes
   int          e_cyc = 0;
   int          done_edge = 0;
   bit          armed = 0;
   bit          pend_ok = 0;
   logic [63:0] pend = '0;
   logic [31:0] m_hi = '0, m_lo = '0;

   always @(posedge clk) begin
      bit was_busy;
      int op;
      was_busy = e_cyc < done_edge;
      e_cyc++;
      if (reset) begin
         armed = 1; m_hi = '0; m_lo = '0; done_edge = e_cyc; pend_ok = 0;
      end else if (was_busy) begin
         if (e_cyc == done_edge && pend_ok) begin
            m_hi = pend[63:32]; m_lo = pend[31:0];
         end
      end else if (en) begin
         if (mult | multu | div | divu) begin
            op = mult ? 0 : multu ? 1 : div ? 2 : 3;
            pend_ok = (op < 2) || (b != 0);
            if (pend_ok) pend = calc(op, a, b);
            done_edge = e_cyc + ((op < 2) ? MC : DC);
         end else if (mthi) m_hi = a;
         else if (mtlo) m_lo = a;
      end
   end

   always @(negedge clk) begin
      logic eb;
      if (armed) begin
         eb = e_cyc < done_edge;
         check("busy", 32'(busy), 32'(eb));
         check("hi", hi, m_hi);
         check("lo", lo, m_lo);
         check("start", 32'(start), 32'(en & (mult | multu | div | divu) & ~eb));
         check("md_use", 32'(md_use), 32'(en & (mult | multu | div | divu | mfhi | mflo | mthi | mtlo)));
         check("rdata", rdata, mfhi ? m_hi : mflo ? m_lo : 32'h0);
      end
   end

   task automatic clr();
      en = 0; mult = 0; multu = 0; div = 0; divu = 0;
      mfhi = 0; mflo = 0; mthi = 0; mtlo = 0; a = '0; b = '0;
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (busy === 1'b1 && n < 100) begin
         n++;
         step();
      end
   endtask

   task automatic run_op(input string nm, input logic [3:0] s, input logic [31:0] x, input logic [31:0] y,
                         input int n, input logic [31:0] eh, input logic [31:0] el);
      int cnt;
      en = 1; {mult, multu, div, divu} = s; a = x; b = y;
      step();
      clr();
      wait_idle(cnt);
      check({nm, "_cycles"}, 32'(cnt), 32'(n));
      check({nm, "_hi"}, hi, eh);
      check({nm, "_lo"}, lo, el);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int cnt;
      clr();
      reset = 1;
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      reset = 0;
      mfhi = 1;
      #1;
      check("rst_rdata", rdata, 32'h0);
      check("rst_hi", hi, 32'h0);
      check("rst_lo", lo, 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      step();
      clr();

      run_op("mult", 4'b1000, 32'hFFFFFFFE, 32'd3, MC, 32'hFFFFFFFF, 32'hFFFFFFFA);
      run_op("multu", 4'b0100, 32'hFFFFFFFE, 32'd3, MC, 32'h00000002, 32'hFFFFFFFA);
      run_op("div", 4'b0010, 32'hFFFFFFF9, 32'd2, DC, 32'hFFFFFFFF, 32'hFFFFFFFD);
      run_op("divu", 4'b0001, 32'd7, 32'd2, DC, 32'd1, 32'd3);

      en = 1; mthi = 1; a = 32'h11111111; step();
      mthi = 0; mtlo = 1; a = 32'h22222222; step();
      clr();
      run_op("div0", 4'b0010, 32'd5, 32'd0, DC, 32'h11111111, 32'h22222222);
      run_op("divovf", 4'b0010, 32'h80000000, 32'hFFFFFFFF, DC, 32'h0, 32'h80000000);
      run_op("prio", 4'b1010, 32'hFFFFFFFE, 32'd3, MC, 32'hFFFFFFFF, 32'hFFFFFFFA);

      en = 0; mthi = 1; a = 32'h55; step(); clr();
      check("en0_hi", hi, 32'hFFFFFFFF);
      en = 1; mthi = 1; mtlo = 1; a = 32'h77; step(); clr();
      check("two_hi", hi, 32'h77);
      check("two_lo", lo, 32'hFFFFFFFA);

      en = 1; mult = 1; a = 32'h00010000; b = 32'h00030000; step();
      a = 32'd1; b = 32'd1; #1;
      check("busy_start", 32'(start), 32'h0);
      check("busy_mduse", 32'(md_use), 32'h1);
      step();
      mult = 0; mtlo = 1; a = 32'hDEAD; #1;
      check("busy_mtlo_mduse", 32'(md_use), 32'h1);
      step();
      clr();
      wait_idle(cnt);
      check("busy_done", 32'(busy), 32'h0);
      check("busy_hi", hi, 32'h3);
      check("busy_lo", lo, 32'h0);
      en = 1; mfhi = 1; #1;
      check("busy_rdata", rdata, 32'h3);
      step();
      clr();

      en = 1; mult = 1; a = 32'hFFFFFFFE; b = 32'd3; step();
      clr();
      step();
      step();
      reset = 1; step(); reset = 0;
      check("abort_busy", 32'(busy), 32'h0);
      check("abort_hi", hi, 32'h0);
      check("abort_lo", lo, 32'h0);
      repeat (12) step();
      check("abort_late_hi", hi, 32'h0);
      check("abort_late_lo", lo, 32'h0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
